// File: rtl/unidad_fetch_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding and default widths/depths.
package unidad_fetch_pkg;

   localparam int ANCHO_DEF       = 32;
   localparam int QUEUE_DEPTH_DEF = 2;

   // ESPERA holds a live request; DESCARTE keeps the bus request up until memory answers, then drops the data.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ESPERA   = 2'd1,
      DESCARTE = 2'd2
   } estado_t;

endpackage

// File: rtl/unidad_fetch_if.sv
// Bundle of PC, instruction-memory, redirect and decode-side signals around the fetch unit.
interface unidad_fetch_if
   import unidad_fetch_pkg::*;
#(
   parameter int ANCHO = ANCHO_DEF
);

   logic [ANCHO-1:0] PC_Actual;
   logic [ANCHO-1:0] PC_Sig;
   logic [ANCHO-1:0] PC_Nuevo;
   logic             PC_Write;
   logic             Mem_Req;
   logic [ANCHO-1:0] Mem_Addr;
   logic             Mem_Ack;
   logic [ANCHO-1:0] Mem_Data;
   logic             Salto;
   logic [ANCHO-1:0] Salto_Dir;
   logic             Inst_Valid;
   logic             Inst_Ready;
   logic [ANCHO-1:0] Inst_Out;
   logic [ANCHO-1:0] Inst_PC;

   modport master (
      input  PC_Actual, PC_Sig, Mem_Ack, Mem_Data, Salto, Salto_Dir, Inst_Ready,
      output PC_Nuevo, PC_Write, Mem_Req, Mem_Addr, Inst_Valid, Inst_Out, Inst_PC
   );

   modport slave (
      output PC_Actual, PC_Sig, Mem_Ack, Mem_Data, Salto, Salto_Dir, Inst_Ready,
      input  PC_Nuevo, PC_Write, Mem_Req, Mem_Addr, Inst_Valid, Inst_Out, Inst_PC
   );

endinterface

// File: rtl/unidad_fetch_cola_inst.sv
// Registered instruction queue (instruction + fetch address) with a synchronous flush.
module cola_inst
   import unidad_fetch_pkg::*;
#(
   parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
   parameter int ANCHO       = ANCHO_DEF
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             push,
   input  logic [ANCHO-1:0] push_inst,
   input  logic [ANCHO-1:0] push_pc,
   input  logic             pop,
   input  logic             flush,
   output logic             valid,
   output logic             full,
   output logic [ANCHO-1:0] head_inst,
   output logic [ANCHO-1:0] head_pc
);

   localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [ANCHO-1:0] mem_inst [QUEUE_DEPTH];
   logic [ANCHO-1:0] mem_pc   [QUEUE_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign valid     = (count != '0);
   assign full      = (count == CW'(QUEUE_DEPTH));
   assign do_pop    = pop && valid && !flush;
   assign do_push   = push && (!full || do_pop) && !flush;
   assign head_inst = mem_inst[rd_ptr];
   assign head_pc   = mem_pc[rd_ptr];

   // Pointer arithmetic wraps naturally because the depth is a power of two.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (do_push) begin
         mem_inst[wr_ptr] <= push_inst;
         mem_pc[wr_ptr]   <= push_pc;
      end
   end

endmodule

// File: rtl/unidad_fetch.sv
// Fetch unit: issues one instruction-memory request at a time, steers the PC register and feeds the decode queue.
module unidad_fetch
   import unidad_fetch_pkg::*;
#(
   parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
   parameter int ANCHO       = ANCHO_DEF
) (
   input logic              Clk,
   input logic              Reset,
   unidad_fetch_if.master   bus
);

   estado_t estado;
   logic    push;
   logic    full;

   // Only a live (non-discarded) ack pushes; a redirect in the same cycle wins.
   assign push = Reset && (estado == ESPERA) && bus.Mem_Ack && !bus.Salto;

   // PC load is combinational so the PC register updates on the same edge the ack or redirect is seen.
   always_comb begin
      bus.PC_Write = 1'b0;
      bus.PC_Nuevo = bus.PC_Sig;
      if (Reset) begin
         if (bus.Salto) begin
            bus.PC_Write = 1'b1;
            bus.PC_Nuevo = bus.Salto_Dir;
         end else if (push) begin
            bus.PC_Write = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         estado       <= IDLE;
         bus.Mem_Req  <= 1'b0;
         bus.Mem_Addr <= '0;
      end else begin
         case (estado)
            IDLE: begin
               if (!full && !bus.Salto) begin
                  estado       <= ESPERA;
                  bus.Mem_Req  <= 1'b1;
                  bus.Mem_Addr <= bus.PC_Actual;
               end
            end
            ESPERA: begin
               if (bus.Mem_Ack) begin
                  estado      <= IDLE;
                  bus.Mem_Req <= 1'b0;
               end else if (bus.Salto) begin
                  estado <= DESCARTE;
               end
            end
            DESCARTE: begin
               if (bus.Mem_Ack) begin
                  estado      <= IDLE;
                  bus.Mem_Req <= 1'b0;
               end
            end
            default: begin
               estado      <= IDLE;
               bus.Mem_Req <= 1'b0;
            end
         endcase
      end
   end

   cola_inst #(
      .QUEUE_DEPTH (QUEUE_DEPTH),
      .ANCHO       (ANCHO)
   ) u_cola (
      .Clk       (Clk),
      .Reset     (Reset),
      .push      (push),
      .push_inst (bus.Mem_Data),
      .push_pc   (bus.Mem_Addr),
      .pop       (bus.Inst_Ready),
      .flush     (Reset && bus.Salto),
      .valid     (bus.Inst_Valid),
      .full      (full),
      .head_inst (bus.Inst_Out),
      .head_pc   (bus.Inst_PC)
   );

endmodule

// File: tb/tb_unidad_fetch.sv
// Bench for unidad_fetch: directed phases with randomized traffic, checked every cycle against a transaction-level model.
module tb_unidad_fetch;

   localparam int ANCHO = 32;
   localparam int DEPTH = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic Clk   = 1'b0;
   logic Reset = 1'b0;

   unidad_fetch_if #(.ANCHO(ANCHO)) bus ();

   unidad_fetch #(
      .QUEUE_DEPTH (DEPTH),
      .ANCHO       (ANCHO)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.master)
   );

   always #5 Clk = ~Clk;

   int tests = 0;
   int fails = 0;

   // Model: PC register, the single outstanding request and the decode queue contents.
   logic [31:0] m_pc   = 32'h0;
   logic [31:0] m_addr = 32'h0;
   bit          m_out  = 1'b0;
   bit          m_drop = 1'b0;
   int          m_wait = 0;
   int          m_lat  = 0;
   ent_t        m_q[$];

   int          lat_mode   = 0;
   int          p_salto    = 0;
   int          p_ready    = 100;
   int          force_mode = 0;
   logic [31:0] force_dir  = 32'h0;

   function automatic logic [31:0] memData(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive at the falling edge, check, then advance the model for the coming rising edge.
   task automatic applyStimulus();
      bit          salto;
      bit          ack;
      bit          ready;
      bit          accept;
      bit          push;
      bit          pop;
      bit          issue;
      bit          exp_write;
      logic [31:0] dir;
      logic [31:0] exp_nuevo;
      logic [31:0] pc_now;
      @(negedge Clk);
      salto = ($urandom_range(0, 99) < p_salto);
      dir   = $urandom & 32'hFFFF_FFFC;
      if (force_mode == 1 && m_out && !m_drop && m_wait == 1) begin
         salto = 1'b1;
         dir = force_dir;
         force_mode = 0;
      end
      ack = m_out ? (m_wait >= m_lat) : ($urandom_range(0, 3) == 0);
      if (force_mode == 2 && m_out && !m_drop && ack) begin
         salto = 1'b1;
         dir = force_dir;
         force_mode = 0;
      end
      ready = ($urandom_range(0, 99) < p_ready);

      bus.PC_Actual  = m_pc;
      bus.PC_Sig     = m_pc + 32'd4;
      bus.Salto      = salto;
      bus.Salto_Dir  = dir;
      bus.Mem_Ack    = ack;
      bus.Mem_Data   = (m_out && ack) ? memData(m_addr) : $urandom;
      bus.Inst_Ready = ready;
      #1;

      accept    = m_out && ack;
      push      = accept && !m_drop && !salto;
      exp_write = salto || push;
      exp_nuevo = salto ? dir : m_pc + 32'd4;

      checkOutput("mem_req", {31'b0, bus.Mem_Req}, {31'b0, m_out});
      checkOutput("mem_addr", bus.Mem_Addr, m_addr);
      checkOutput("pc_write", {31'b0, bus.PC_Write}, {31'b0, exp_write});
      if (exp_write) checkOutput("pc_nuevo", bus.PC_Nuevo, exp_nuevo);
      checkOutput("inst_valid", {31'b0, bus.Inst_Valid}, {31'b0, (m_q.size() > 0)});
      if (m_q.size() > 0) begin
         checkOutput("inst_pc", bus.Inst_PC, m_q[0].pc);
         checkOutput("inst_out", bus.Inst_Out, m_q[0].inst);
      end

      pop    = (m_q.size() > 0) && ready;
      issue  = !m_out && !salto && (m_q.size() < DEPTH);
      pc_now = m_pc;

      if (salto) m_q.delete();
      else begin
         if (pop) void'(m_q.pop_front());
         if (push) m_q.push_back('{pc: m_addr, inst: memData(m_addr)});
      end
      if (exp_write) m_pc = exp_nuevo;

      if (m_out) begin
         if (accept) m_out = 1'b0;
         else begin
            if (salto) m_drop = 1'b1;
            m_wait++;
         end
      end else if (issue) begin
         m_out  = 1'b1;
         m_drop = 1'b0;
         m_addr = pc_now;
         m_wait = 0;
         m_lat  = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_mem_req"}, {31'b0, bus.Mem_Req}, 32'h0);
      checkOutput({tag, "_mem_addr"}, bus.Mem_Addr, 32'h0);
      checkOutput({tag, "_pc_write"}, {31'b0, bus.PC_Write}, 32'h0);
      checkOutput({tag, "_inst_valid"}, {31'b0, bus.Inst_Valid}, 32'h0);
   endtask

   task automatic modelReset();
      m_pc   = 32'h0;
      m_addr = 32'h0;
      m_out  = 1'b0;
      m_drop = 1'b0;
      m_wait = 0;
      m_q.delete();
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   initial begin
      bus.PC_Actual  = 32'h0;
      bus.PC_Sig     = 32'h4;
      bus.Salto      = 1'b0;
      bus.Salto_Dir  = 32'h0;
      bus.Mem_Ack    = 1'b0;
      bus.Mem_Data   = 32'h0;
      bus.Inst_Ready = 1'b1;

      // Power-on reset, with a redirect pulse that must not reach the PC while reset is held.
      #3;
      bus.Salto = 1'b1;
      #1;
      checkResetState("por");
      bus.Salto = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #2;
      Reset = 1'b1;
      modelReset();

      // Zero-latency memory, decode always ready: one instruction per two cycles from 0x0.
      lat_mode = 0; p_salto = 0; p_ready = 100;
      runCycles(12);

      // Decode stalled with latency 1: queue fills to two and issue stops, then resumes.
      lat_mode = 1; p_ready = 0;
      runCycles(12);
      p_ready = 100;
      runCycles(10);

      // Redirect to 0x100 while a latency-3 request is outstanding.
      lat_mode = 3; force_mode = 1; force_dir = 32'h100;
      runCycles(16);

      // Redirect to 0x40 in the very cycle memory answers, with entries already queued.
      lat_mode = 2; p_ready = 0;
      runCycles(8);
      force_mode = 2; force_dir = 32'h40;
      runCycles(6);

      // Full queue draining while new fetches land.
      lat_mode = 0; p_ready = 0;
      runCycles(8);
      p_ready = 50;
      runCycles(20);

      // Randomized mix of latencies, redirects and decode back-pressure.
      force_mode = 0; lat_mode = -1; p_salto = 10; p_ready = 60;
      runCycles(300);

      // Asynchronous reset in the middle of a long request; acks around the release must be ignored.
      lat_mode = 6; p_salto = 0; p_ready = 100;
      for (int i = 0; i < 12 && !(bus.Mem_Req && m_lat == 6); i++) applyStimulus();
      checkOutput("req_before_reset", {31'b0, bus.Mem_Req}, 32'h1);
      @(posedge Clk);
      #2;
      Reset = 1'b0;
      bus.Mem_Ack = 1'b1;
      bus.Salto = 1'b1;
      #1;
      checkResetState("async");
      @(posedge Clk);
      @(posedge Clk);
      #2;
      bus.Salto = 1'b0;
      Reset = 1'b1;
      modelReset();
      lat_mode = 0;
      runCycles(12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/unidad_fetch.md
UNIDAD_FETCH -- requirements
Module: unidad_fetch

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 2, meaning instruction-queue entries (power of two, >=2).
REQ-002 SHALL have parameter ANCHO, default 32, meaning address/instruction width in bits.
REQ-003 Clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 PC_Actual  in  ANCHO  current PC from the PC register output.
REQ-006 PC_Sig  in  ANCHO  PC+4 from the PC register.
REQ-007 PC_Nuevo  out  ANCHO  next value for the PC register input.
REQ-008 PC_Write  out  1  PC register load enable, one-cycle pulse.
REQ-009 Mem_Req  out  1  instruction-memory request.
REQ-010 Mem_Addr  out  ANCHO  registered fetch address.
REQ-011 Mem_Ack  in  1  memory completion, valid only while Mem_Req=1.
REQ-012 Mem_Data  in  ANCHO  fetched instruction, valid with Mem_Ack.
REQ-013 Salto  in  1  branch/jump redirect from execute, one-cycle pulse.
REQ-014 Salto_Dir  in  ANCHO  redirect target, valid with Salto.
REQ-015 Inst_Valid  out  1  queue head valid toward decode.
REQ-016 Inst_Ready  in  1  decode accepts the head.
REQ-017 Inst_Out, Inst_PC  out  ANCHO each  head instruction and its fetch address.

Function
REQ-018 FSM states SHALL be IDLE, ESPERA (request outstanding), DESCARTE (outstanding request to be discarded).
REQ-019 IDLE->ESPERA SHALL occur when count<QUEUE_DEPTH and Salto=0; Mem_Addr SHALL capture PC_Actual on that edge.
REQ-020 Mem_Req SHALL be 1 exactly in ESPERA and DESCARTE; Mem_Addr SHALL stay constant until the accepting Mem_Ack.
REQ-021 In ESPERA with Mem_Ack=1 and Salto=0: push {Mem_Addr, Mem_Data}, PC_Write=1, PC_Nuevo=PC_Sig, next state IDLE.
REQ-022 On Salto=1 in any state: flush queue (count=0), PC_Write=1, PC_Nuevo=Salto_Dir.
REQ-023 Salto in ESPERA without Mem_Ack SHALL go to DESCARTE; Mem_Req SHALL stay 1 until Mem_Ack.
REQ-024 Salto coincident with Mem_Ack (ESPERA or DESCARTE) SHALL discard Mem_Data and go to IDLE.
REQ-025 In DESCARTE, Mem_Ack SHALL discard data, produce no PC_Write, and go to IDLE.
REQ-026 PC_Write SHALL be 0 in every cycle not covered by REQ-021/022; Salto has priority over the ack push.
REQ-027 Inst_Valid SHALL equal (count>0); handshake completes when Inst_Valid and Inst_Ready are both 1, popping the head.
REQ-028 Push and pop in the same cycle SHALL leave count unchanged; flush overrides a simultaneous pop and push.
REQ-029 Inst_Out/Inst_PC SHALL be stable while Inst_Valid=1 and Inst_Ready=0.
REQ-030 Pushed data SHALL appear at the head no earlier than the cycle after Mem_Ack (registered queue); best-case throughput is one instruction per 2 cycles.
REQ-031 Queue pointers SHALL wrap modulo QUEUE_DEPTH; count SHALL never exceed QUEUE_DEPTH.

Reset
REQ-032 While Reset=0: state IDLE, count 0, pointers 0, Mem_Addr 0, Mem_Req 0, PC_Write 0, Inst_Valid 0.
REQ-033 Reset asserted mid-request SHALL abandon the request; a Mem_Ack arriving after release with Mem_Req=0 SHALL be ignored.
REQ-034 Issue SHALL begin at the first rising edge after reset deassertion.

Structure
REQ-035 Shared package SHALL hold the FSM state encoding, ANCHO default and QUEUE_DEPTH default.
REQ-036 The queue SHALL be a sub-module cola_inst (parameterised FIFO with flush); FSM and PC logic stay in unidad_fetch.

Verification
REQ-037 Reset release, PC_Actual=0x0, zero-latency memory, Inst_Ready=1 -> Mem_Addr 0x0,0x4,0x8 in order; PC_Write every 2 cycles; Inst_PC matches.
REQ-038 Inst_Ready=0, memory latency 1 -> exactly 2 instructions queued, Mem_Req stays 0 afterward; Inst_Ready=1 -> fetching resumes.
REQ-039 Salto=1, Salto_Dir=0x100 during ESPERA with latency 3 -> Mem_Req held until ack, data dropped, next Mem_Addr=0x100, queue empty.
REQ-040 Salto coincident with Mem_Ack, Salto_Dir=0x40 -> PC_Nuevo=0x40, no push, Inst_Valid=0 next cycle.
REQ-041 Full queue plus push/pop in the same cycle -> count stays 2; head advances in FIFO order.
REQ-042 Reset=0 asserted mid-ESPERA -> all outputs at reset values immediately (asynchronous), late Mem_Ack ignored.
